if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter and drives the word address into the instruction ROM. It captures the returned instruction word into the IF/ID pipeline register. It also applies stall holds and branch/jump redirects coming back from the ID and EX/MEM stages.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/if_fetch_stage_if.sv | 28 ++
 rtl/pc_reg.sv | 47 ++++
 rtl/if_fetch_stage.sv | 66 ++++++
 tb/tb_if_fetch_stage.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Purpose: constants shared by the MIPS pipeline stages (reset values, opcodes, jump formation).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;   // sll $0,$0,0
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Primary opcodes seen by ID when it classifies control flow.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Pseudo-direct jump address: region bits come from PC+4 of the jump itself.
    function automatic logic [31:0] form_jump_target(input logic [31:0] pc4,
                                                     input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Purpose: bundles the fetch stage's pipeline-facing signals (redirects, stall, ROM, IF/ID).
// Latency: n/a (wiring only).
// Backpressure: stall holds the stage; redirects override stall.
// Ports: master = fetch stage side, slave = hazard unit / ID / EX / ROM side.
interface if_fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        misalign_err;

    modport master (
        input  stall, branch_taken, branch_target, jump_taken, jump_target, imem_data,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, misalign_err
    );

    modport slave (
        output stall, branch_taken, branch_target, jump_taken, jump_target, imem_data,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, misalign_err
    );
endinterface

// File: rtl/pc_reg.sv
// Purpose: program counter with next-PC select (branch > jump > stall > +4) and word-alignment forcing.
// Latency: new PC visible the cycle after the select; pc_plus4 is combinational.
// Backpressure: stall holds PC unless a redirect is present.
// Ports: clk/reset_n, stall and redirect inputs in; pc, pc_plus4 and sticky misalign_err out.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    logic        redirect;
    logic [31:0] redirect_target;

    // Branch wins over jump: the branch belongs to the older instruction.
    always_comb begin
        redirect        = branch_taken | jump_taken;
        redirect_target = branch_taken ? branch_target : jump_target;
        pc_plus4        = pc + WORD_BYTES;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else if (redirect) begin
            pc <= {redirect_target[31:2], 2'b00};
            // Only the selected target is inspected; the losing one is ignored.
            if (redirect_target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Purpose: MIPS instruction fetch: owns PC, drives ROM address, captures the word into IF/ID.
// Latency: imem_addr = pc combinationally; the word at pc lands in IF/ID on the next edge.
// Backpressure: stall freezes PC, IF/ID and fetch_count; redirects squash IF/ID even under stall.
// Ports: clk, reset_n (sync, active low); bus (master) carries stall/redirects/ROM/IF-ID/status.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    if_fetch_stage_if.master  bus
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;
    logic        redirect;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (bus.stall),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump_taken    (bus.jump_taken),
        .jump_target   (bus.jump_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misalign_err  (misalign_err)
    );

    assign redirect = bus.branch_taken | bus.jump_taken;

    // IF/ID register and accepted-instruction counter. A squash keeps pc4
    // as-is; only valid and the instruction word are cleared.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fetch_count <= 32'd0;
        end else if (redirect) begin
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
        end else if (!bus.stall) begin
            if_id_instr <= bus.imem_data;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign bus.imem_addr    = pc;
    assign bus.if_id_instr  = if_id_instr;
    assign bus.if_id_pc4    = if_id_pc4;
    assign bus.if_id_valid  = if_id_valid;
    assign bus.fetch_count  = fetch_count;
    assign bus.misalign_err = misalign_err;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] W_LW  = 32'h8C08_0000;
    localparam logic [31:0] W_ADD = 32'h0109_5020;
    localparam logic [31:0] W_AD2 = 32'h0109_5820;

    // Instruction ROM model: a few fixed words, everything else tagged with its address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return W_LW;
            32'h0000_0004: return W_ADD;
            32'h0000_0008: return 32'h0000_0000;
            32'h0000_000C: return 32'h0000_0000;
            32'h0000_0020: return W_AD2;
            default:       return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    always_comb bus.imem_data = rom_word(bus.imem_addr);

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic stall, logic br, logic [31:0] bt,
                                logic jp, logic [31:0] jt, logic [31:0] e_pc,
                                logic [31:0] e_instr, logic [31:0] e_pc4, logic e_valid,
                                logic [31:0] e_cnt, logic e_mis);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
        v.e_cnt = e_cnt; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic stall, input logic br,
                         input logic [31:0] bt, input logic jp, input logic [31:0] jt);
        reset_n           = rst_n;
        bus.stall         = stall;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.jump_taken    = jp;
        bus.jump_target   = jt;
    endtask

    task automatic expect_all(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid, input logic [31:0] e_cnt, input logic e_mis);
        check({tag, " imem_addr"},    bus.imem_addr,           e_pc);
        check({tag, " if_id_instr"},  bus.if_id_instr,         e_instr);
        check({tag, " if_id_pc4"},    bus.if_id_pc4,           e_pc4);
        check({tag, " if_id_valid"},  {31'd0, bus.if_id_valid}, {31'd0, e_valid});
        check({tag, " fetch_count"},  bus.fetch_count,         e_cnt);
        check({tag, " misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, e_mis});
    endtask

    // One edge: apply inputs, clock, sample 1 time unit after the edge.
    task automatic step(input vec_t v, input string tag);
        drive(v.rst_n, v.stall, v.br, v.bt, v.jp, v.jt);
        @(posedge clk);
        #1;
        expect_all(tag, v.e_pc, v.e_instr, v.e_pc4, v.e_valid, v.e_cnt, v.e_mis);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        //            rst stl br bt             jp jt             pc            instr         pc4           v  cnt  mis
        // reset held two edges
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0,  0));
        // sequential fetch 0,4
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h4,        W_LW,         32'h4,        1, 1,  0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        W_ADD,        32'h8,        1, 2,  0));
        // three stall cycles at pc=8
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h8,        W_ADD,        32'h8,        1, 2,  0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h8,        W_ADD,        32'h8,        1, 2,  0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h8,        W_ADD,        32'h8,        1, 2,  0));
        // resume; NOP words from ROM are counted as valid
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'h0,        32'hC,        1, 3,  0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'h0,        32'h10,       1, 4,  0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h14,       32'hC0DE0010, 32'h14,       1, 5,  0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h18,       32'hC0DE0014, 32'h18,       1, 6,  0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h1C,       32'hC0DE0018, 32'h1C,       1, 7,  0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h20,       32'hC0DE001C, 32'h20,       1, 8,  0));
        // jump at pc=0x20 to 0x34: squash, add at 0x20 never accepted
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h34,       32'h34,       32'h0,        32'h20,       0, 8,  0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h38,       32'hC0DE0034, 32'h38,       1, 9,  0));
        // branch + jump + stall together: branch wins
        vecs.push_back(mk(1, 1, 1, 32'hC,        1, 32'h40,       32'hC,        32'h0,        32'h38,       0, 9,  0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'h0,        32'h10,       1, 10, 0));
        // misaligned jump target loses to aligned branch: ignored
        vecs.push_back(mk(1, 0, 1, 32'h20,       1, 32'h43,       32'h20,       32'h0,        32'h10,       0, 10, 0));
        // misaligned branch target: forced to 0x10, sticky error
        vecs.push_back(mk(1, 0, 1, 32'h12,       0, 32'h0,        32'h10,       32'h0,        32'h10,       0, 10, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h14,       32'hC0DE0010, 32'h14,       1, 11, 1));
        // jump to top word, then wrap to 0
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h14,       0, 11, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'hC0DEFFFC, 32'h0,        1, 12, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h4,        W_LW,         32'h4,        1, 13, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-stall: get to pc=0x18, stall, then reset while still stalling.
        step(mk(1, 0, 0, 32'h0, 1, 32'h18, 32'h18, 32'h0, 32'h4, 0, 13, 1), "rs_jump");
        step(mk(1, 1, 0, 32'h0, 0, 32'h0,  32'h18, 32'h0, 32'h4, 0, 13, 1), "rs_stall");
        step(mk(0, 1, 0, 32'h0, 0, 32'h0,  32'h0,  32'h0, 32'h0, 0, 0,  0), "rs_reset");
        step(mk(1, 0, 0, 32'h0, 0, 32'h0,  32'h4,  W_LW,  32'h4, 1, 1,  0), "rs_fetch0");

        // Reset during a redirect: redirect has no effect on that edge.
        step(mk(0, 0, 1, 32'h33, 1, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 0), "rr_reset");
        step(mk(1, 0, 0, 32'h0, 0, 32'h0,  32'h4,  W_LW,  32'h4, 1, 1,  0), "rr_fetch0");
        step(mk(1, 0, 0, 32'h0, 0, 32'h0,  32'h8,  W_ADD, 32'h8, 1, 2,  0), "rr_fetch1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
